// File: rtl/cpu_fetch_pkg.sv
// Shared types for the 65C816 instruction fetch sequencer.
// Imported by the fetch interface and the sequencer itself.
package cpu_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPCODE  = 2'd1,
    OPERAND = 2'd2,
    HOLD    = 2'd3
  } fetch_state_t;

  localparam int OPERAND_MAX = 3;
  localparam int IDX_W = $clog2(OPERAND_MAX + 1);

endpackage

// File: rtl/cpu_fetch_seq_if.sv
// Fetch-to-execute instruction handshake bundle.
// The master side is the fetch sequencer; the slave side is execute.
interface cpu_fetch_seq_if;
  import cpu_fetch_pkg::*;

  logic        fetch_req;
  logic        flush;
  logic [1:0]  operand_len;
  logic [7:0]  opcode;
  logic [23:0] operand;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    input  fetch_req,
    input  flush,
    input  operand_len,
    input  instr_ready,
    output opcode,
    output operand,
    output instr_valid
  );

  modport slave (
    output fetch_req,
    output flush,
    output operand_len,
    output instr_ready,
    input  opcode,
    input  operand,
    input  instr_valid
  );

endinterface

// File: rtl/cpu_fetch_seq.sv
// Opcode/operand fetch sequencer: reads bytes at {pbr, pc}, strobes the
// PC increment once per byte and hands the instruction to execute.
module cpu_fetch_seq
  import cpu_fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_en,
  input  logic [15:0]           pc,
  input  logic [7:0]            pbr,
  output logic                  pc_inc,
  output logic [23:0]           bus_addr,
  output logic                  bus_rd,
  input  logic [7:0]            bus_rdata,
  cpu_fetch_seq_if.master       ex
);

  fetch_state_t     state;
  logic [IDX_W-1:0] byte_idx;
  logic [7:0]       opcode_q;
  logic [23:0]      operand_q;
  logic             more;
  logic             rd_cyc;

  assign more   = (byte_idx != ex.operand_len);
  assign rd_cyc = (state == OPCODE) ||
                  ((state == OPERAND) && more);

  assign bus_addr = {pbr, pc};
  assign bus_rd   = rd_cyc;
  // The byte lands on the same edge the PC advances.
  assign pc_inc   = rd_cyc & cpu_en & ~ex.flush;

  assign ex.opcode      = opcode_q;
  assign ex.operand     = operand_q;
  assign ex.instr_valid = (state == HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      byte_idx  <= '0;
      opcode_q  <= 8'h00;
      operand_q <= 24'h000000;
    end else if (cpu_en) begin
      if (ex.flush) begin
        state    <= IDLE;
        byte_idx <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (ex.fetch_req)
              state <= OPCODE;
          end
          OPCODE: begin
            opcode_q  <= bus_rdata;
            operand_q <= 24'h000000;
            byte_idx  <= '0;
            state     <= OPERAND;
          end
          OPERAND: begin
            if (more) begin
              operand_q[{byte_idx, 3'b000} +: 8] <= bus_rdata;
              byte_idx <= byte_idx + 1'b1;
            end else begin
              state <= HOLD;
            end
          end
          HOLD: begin
            if (ex.instr_ready)
              state <= ex.fetch_req ? OPCODE : IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_fetch_seq.sv
// Directed bench for cpu_fetch_seq with a PC register model and a
// 16-byte memory window indexed by the low address nibble.
module tb_cpu_fetch_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_en;
  logic [15:0] pc;
  logic [7:0]  pbr;
  logic        pc_inc;
  logic [23:0] bus_addr;
  logic        bus_rd;
  logic [7:0]  bus_rdata;
  logic        pc_ld;
  logic [15:0] pc_ld_val;
  logic [7:0]  mem [16];

  int total = 0;
  int bad   = 0;

  cpu_fetch_seq_if ex_if ();

  cpu_fetch_seq dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_en    (cpu_en),
    .pc        (pc),
    .pbr       (pbr),
    .pc_inc    (pc_inc),
    .bus_addr  (bus_addr),
    .bus_rd    (bus_rd),
    .bus_rdata (bus_rdata),
    .ex        (ex_if.master)
  );

  always #5 clk = ~clk;

  assign bus_rdata = mem[bus_addr[3:0]];

  always @(posedge clk) begin
    if (pc_ld)
      pc <= pc_ld_val;
    else if (pc_inc)
      pc <= pc + 16'h0001;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_pc(input logic [15:0] v);
    pc_ld     = 1'b1;
    pc_ld_val = v;
    tick();
    pc_ld = 1'b0;
  endtask

  task automatic release_hold();
    ex_if.instr_ready = 1'b1;
    ex_if.fetch_req   = 1'b0;
    tick();
    ex_if.instr_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cpu_en = 1'b1;
    pbr = 8'h00;
    pc_ld = 1'b0;
    pc_ld_val = 16'h0000;
    ex_if.fetch_req = 1'b0;
    ex_if.flush = 1'b0;
    ex_if.operand_len = 2'd0;
    ex_if.instr_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_valid", 32'(ex_if.instr_valid), 32'h0);
    chk("rst_bus_rd", 32'(bus_rd), 32'h0);
    chk("rst_pc_inc", 32'(pc_inc), 32'h0);
    chk("rst_opcode", 32'(ex_if.opcode), 32'h00);
    chk("rst_operand", 32'(ex_if.operand), 32'h0);

    // 1: LDA #$1234, len=2
    mem[0] = 8'hA9; mem[1] = 8'h34; mem[2] = 8'h12;
    ex_if.operand_len = 2'd2;
    load_pc(16'h8000);
    ex_if.fetch_req = 1'b1;
    #1;
    chk("s1_idle_rd", 32'(bus_rd), 32'h0);
    tick();
    ex_if.fetch_req = 1'b0;
    chk("s1_addr0", 32'(bus_addr), 32'h008000);
    chk("s1_inc0", 32'(pc_inc), 32'h1);
    tick();
    chk("s1_addr1", 32'(bus_addr), 32'h008001);
    chk("s1_inc1", 32'(pc_inc), 32'h1);
    tick();
    chk("s1_addr2", 32'(bus_addr), 32'h008002);
    chk("s1_inc2", 32'(pc_inc), 32'h1);
    tick();
    chk("s1_dead_inc", 32'(pc_inc), 32'h0);
    chk("s1_dead_rd", 32'(bus_rd), 32'h0);
    chk("s1_dead_vld", 32'(ex_if.instr_valid), 32'h0);
    tick();
    chk("s1_valid", 32'(ex_if.instr_valid), 32'h1);
    chk("s1_opcode", 32'(ex_if.opcode), 32'hA9);
    chk("s1_operand", 32'(ex_if.operand), 32'h001234);
    chk("s1_pc", 32'(pc), 32'h8003);
    release_hold();
    chk("s1_released", 32'(ex_if.instr_valid), 32'h0);

    // 2: NOP, len=0
    mem[3] = 8'hEA;
    ex_if.operand_len = 2'd0;
    ex_if.fetch_req = 1'b1;
    tick();
    ex_if.fetch_req = 1'b0;
    chk("s2_inc", 32'(pc_inc), 32'h1);
    tick();
    chk("s2_dead_rd", 32'(bus_rd), 32'h0);
    chk("s2_dead_vld", 32'(ex_if.instr_valid), 32'h0);
    tick();
    chk("s2_valid", 32'(ex_if.instr_valid), 32'h1);
    chk("s2_opcode", 32'(ex_if.opcode), 32'hEA);
    chk("s2_operand", 32'(ex_if.operand), 32'h0);
    chk("s2_pc", 32'(pc), 32'h8004);
    release_hold();

    // 3: cpu_en stalls mid-operand
    mem[0] = 8'hA9; mem[1] = 8'h34; mem[2] = 8'h12;
    ex_if.operand_len = 2'd2;
    load_pc(16'h8000);
    ex_if.fetch_req = 1'b1;
    tick();
    ex_if.fetch_req = 1'b0;
    tick();
    cpu_en = 1'b0;
    #1;
    chk("s3_stall_inc", 32'(pc_inc), 32'h0);
    chk("s3_stall_rd", 32'(bus_rd), 32'h1);
    tick();
    tick();
    chk("s3_stall_pc", 32'(pc), 32'h8001);
    chk("s3_stall_addr", 32'(bus_addr), 32'h008001);
    chk("s3_stall_vld", 32'(ex_if.instr_valid), 32'h0);
    cpu_en = 1'b1;
    tick();
    tick();
    tick();
    chk("s3_valid", 32'(ex_if.instr_valid), 32'h1);
    chk("s3_opcode", 32'(ex_if.opcode), 32'hA9);
    chk("s3_operand", 32'(ex_if.operand), 32'h001234);
    chk("s3_pc", 32'(pc), 32'h8003);
    release_hold();

    // 4: PC wrap without bank carry
    pbr = 8'h7E;
    mem[15] = 8'hA5; mem[0] = 8'h42;
    ex_if.operand_len = 2'd1;
    load_pc(16'hFFFF);
    ex_if.fetch_req = 1'b1;
    tick();
    ex_if.fetch_req = 1'b0;
    chk("s4_addr0", 32'(bus_addr), 32'h7EFFFF);
    tick();
    chk("s4_addr1", 32'(bus_addr), 32'h7E0000);
    chk("s4_inc1", 32'(pc_inc), 32'h1);
    tick();
    tick();
    chk("s4_valid", 32'(ex_if.instr_valid), 32'h1);
    chk("s4_opcode", 32'(ex_if.opcode), 32'hA5);
    chk("s4_operand", 32'(ex_if.operand), 32'h000042);
    chk("s4_addr_end", 32'(bus_addr), 32'h7E0001);
    release_hold();

    // 5: flush on second operand read, len=3
    pbr = 8'h00;
    mem[0] = 8'h5C; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33;
    ex_if.operand_len = 2'd3;
    load_pc(16'h8000);
    ex_if.fetch_req = 1'b1;
    tick();
    ex_if.fetch_req = 1'b0;
    tick();
    tick();
    ex_if.flush = 1'b1;
    #1;
    chk("s5_flush_inc", 32'(pc_inc), 32'h0);
    chk("s5_flush_rd", 32'(bus_rd), 32'h1);
    tick();
    ex_if.flush = 1'b0;
    #1;
    chk("s5_idle_rd", 32'(bus_rd), 32'h0);
    chk("s5_pc", 32'(pc), 32'h8002);
    chk("s5_opcode", 32'(ex_if.opcode), 32'h5C);
    chk("s5_operand", 32'(ex_if.operand), 32'h000011);
    tick();
    chk("s5_vld", 32'(ex_if.instr_valid), 32'h0);

    // 6: long HOLD then back-to-back fetch
    mem[0] = 8'hA9; mem[1] = 8'h34; mem[2] = 8'h12;
    ex_if.operand_len = 2'd2;
    load_pc(16'h8000);
    ex_if.fetch_req = 1'b1;
    tick();
    ex_if.fetch_req = 1'b0;
    tick();
    tick();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("s6_hold_vld", 32'(ex_if.instr_valid), 32'h1);
      chk("s6_hold_op", 32'(ex_if.opcode), 32'hA9);
      chk("s6_hold_opnd", 32'(ex_if.operand), 32'h001234);
      chk("s6_hold_rd", 32'(bus_rd), 32'h0);
      chk("s6_hold_pc", 32'(pc), 32'h8003);
      tick();
    end
    ex_if.instr_ready = 1'b1;
    ex_if.fetch_req = 1'b1;
    tick();
    ex_if.instr_ready = 1'b0;
    ex_if.fetch_req = 1'b0;
    #1;
    chk("s6_b2b_rd", 32'(bus_rd), 32'h1);
    chk("s6_b2b_vld", 32'(ex_if.instr_valid), 32'h0);
    chk("s6_b2b_addr", 32'(bus_addr), 32'h008003);
    chk("s6_b2b_inc", 32'(pc_inc), 32'h1);

    // Reset mid-fetch wins over a stalled cpu_en
    cpu_en = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cpu_en = 1'b1;
    #1;
    chk("rst_mid_rd", 32'(bus_rd), 32'h0);
    chk("rst_mid_op", 32'(ex_if.opcode), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_fetch_seq.md
Name: cpu_fetch_seq

Overview:
- Instruction fetch sequencer for the 65C816 core.
- Reads the opcode byte and then 0-3 operand bytes from program memory at {PBR, PC}.
- Drives the increment input of the 16-bit PC register once per byte read.
- Presents the assembled opcode and operand to the execute stage over a valid/ready handshake.

Parameters:
- None. Widths are fixed by the CPU architecture.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_en  in  1  CPU clock enable; all state advances only on cycles with cpu_en=1
- pc  in  16  current PC, taken from the PC register read data
- pbr  in  8  program bank register
- pc_inc  out  1  increment strobe to the PC register
- bus_addr  out  24  read address
- bus_rd  out  1  read request
- bus_rdata  in  8  read data, valid on the cpu_en cycle in which bus_rd=1
- fetch_req  in  1  execute stage requests the next instruction
- flush  in  1  abort fetch (branch, interrupt or mode change)
- operand_len  in  2  operand byte count (0-3), decoded combinationally from the opcode output plus M/X flags
- opcode  out  8  fetched opcode
- operand  out  24  operand bytes, little-endian
- instr_valid  out  1  instruction complete and held
- instr_ready  in  1  execute stage accepts the instruction

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. Reset has priority over cpu_en.
- Reset values: state=IDLE, byte_idx=0, opcode=0x00, operand=0x000000, instr_valid=0, bus_rd=0, pc_inc=0.
- bus_addr = {pbr, pc} combinationally at all times. The bank never carries; PC wraps 0xFFFF to 0x0000 inside the PC register.
- cpu_en=0: all registers hold, pc_inc=0, bus_rd keeps its state-derived value.
- Read cycle: state=OPCODE, or state=OPERAND with byte_idx != operand_len. In a read cycle bus_rd=1 and pc_inc = cpu_en & ~flush.
- Single-cycle PC update: data is captured on the same cpu_en edge on which the PC increments, so the next read sees pc+1.
- IDLE: bus_rd=0. On cpu_en with fetch_req=1 and flush=0, go to OPCODE.
- OPCODE: on cpu_en, opcode<=bus_rdata, operand<=0, byte_idx<=0, go to OPERAND.
- OPERAND, byte_idx < operand_len: on cpu_en, operand[8*byte_idx+7 : 8*byte_idx] <= bus_rdata and byte_idx<=byte_idx+1.
- OPERAND, byte_idx == operand_len: no read, no increment; go to HOLD. This is one dead cycle, including when len=0.
- operand_len is sampled every OPERAND cycle. The decoder must hold it stable while opcode is stable.
- HOLD: instr_valid=1; opcode and operand held stable.
  - On cpu_en with instr_ready=1: go to OPCODE if fetch_req=1, else IDLE.
  - instr_ready=0: stay in HOLD indefinitely.
- Latency: fetch_req accepted in IDLE at edge N gives instr_valid high after edge N+len+2, counting cpu_en edges.
- Back-to-back fetch from HOLD to OPCODE has no IDLE bubble.
- flush=1 on a cpu_en cycle in any state:
  - next state IDLE, instr_valid<=0, byte_idx<=0;
  - pc_inc=0 in that cycle, so the PC is not advanced;
  - opcode and operand keep their last values.
- flush has priority over fetch_req and instr_ready.
- flush during cpu_en=0 has no effect.
- Reset mid-fetch: returns to IDLE immediately on the next clk edge, whatever cpu_en is.

Decomposition:
- Package cpu_fetch_pkg holds:
  - the state enum fetch_state_t {IDLE, OPCODE, OPERAND, HOLD} (2-bit);
  - the constant OPERAND_MAX=3.
- No sub-module. The PC register and the operand-length decoder are instantiated by the parent CPU.
- Target implementation: about 150 lines.

Test Plan:
1. Reset, then pbr=0x00, pc=0x8000, memory 0xA9 0x34 0x12, len=2, fetch_req=1, instr_ready=0. Expect bus_addr 0x008000, 0x008001, 0x008002 with pc_inc high 3 cycles, one dead cycle, then instr_valid=1, opcode=0xA9, operand=0x001234, PC=0x8003.
2. Opcode 0xEA with len=0. Expect one read, instr_valid after 2 cpu_en edges, operand=0x000000, PC advanced by 1.
3. cpu_en toggled 1-0-0-1 during an operand fetch. Expect no PC change and no state change on cpu_en=0 cycles; final result identical to scenario 1.
4. pc=0xFFFF, pbr=0x7E, len=1. Expect reads at 0x7EFFFF then 0x7E0000, and no bank increment.
5. flush asserted on the second operand-read cycle of a len=3 fetch. Expect pc_inc=0 that cycle, next state IDLE, instr_valid stays 0, PC advanced by exactly 2.
6. HOLD with instr_ready=0 for 5 cycles, then instr_ready=1 with fetch_req=1. Expect outputs stable for all 5 cycles, then OPCODE next cycle with bus_rd=1 and no IDLE cycle.
